// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants, redirect kinds and target computation for fetch_unit
package fetch_unit_pkg;

   localparam int          INSTR_W          = 32;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

   typedef enum logic [1:0] {
      KIND_BR   = 2'd0,
      KIND_J    = 2'd1,
      KIND_JR   = 2'd2,
      KIND_RSVD = 2'd3
   } redir_kind_e;

   // The reserved kind deliberately falls into the register-jump path.
   function automatic logic [31:0] redir_target(input redir_kind_e kind,
                                                input logic [31:0] base,
                                                input logic [31:0] imm,
                                                input logic [25:0] idx,
                                                input logic [31:0] rreg);
      logic [31:0] tgt;
      case (kind)
         KIND_BR: tgt = base + 32'd4 + {imm[29:0], 2'b00};
         KIND_J:  tgt = {base[31:28], idx, 2'b00};
         default: tgt = {rreg[31:2], 2'b00};
      endcase
      return tgt;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - fetch queue: power-of-two circular buffer with sync reset and flush
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int WIDTH = 2 * INSTR_W,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] pop_data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [AW:0]      count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_q, wr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;

   // Flush voids any push or pop presented in the same cycle.
   assign do_push = push_i & ~full_o & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= push_data_i;
   end

   assign empty_o    = (count_q == '0);
   assign full_o     = (count_q == (AW+1)'(DEPTH));
   assign count_o    = count_q;
   assign pop_data_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: single-outstanding request FSM, redirect handling, fetch queue
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          QDEPTH   = 4
) (
   input  logic         clk,
   input  logic         rst,
   output logic         imem_req,
   output logic [31:0]  imem_addr,
   input  logic         imem_ready,
   input  logic         imem_rvalid,
   input  logic [31:0]  imem_rdata,
   input  logic         redir_valid,
   input  logic [1:0]   redir_kind,
   input  logic [31:0]  redir_base,
   input  logic [31:0]  redir_imm,
   input  logic [25:0]  redir_idx,
   input  logic [31:0]  redir_reg,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [31:0]  out_instr,
   output logic [31:0]  out_pc,
   output logic [31:0]  out_pcplus8
);

   localparam int         CW     = $clog2(QDEPTH) + 1;
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] inflight_pc_q, inflight_pc_d;
   logic        discard_q, discard_d;

   logic [31:0] target;
   logic        accept, resp, push, pop;
   logic        fifo_full, fifo_empty;
   logic [CW-1:0] fifo_count;

   assign target   = redir_target(redir_kind_e'(redir_kind), redir_base, redir_imm, redir_idx, redir_reg);
   assign imem_req = ~rst & (state_q == S_IDLE) & ~redir_valid & (fifo_count < CW'(QDEPTH));
   assign imem_addr = fetch_pc_q;
   assign accept   = imem_req & imem_ready;
   assign resp     = (state_q == S_WAIT) & imem_rvalid;
   assign push     = resp & ~discard_q & ~redir_valid & ~fifo_full;
   assign pop      = out_valid & out_ready;

   always_comb begin
      state_d       = state_q;
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      discard_d     = discard_q;
      if (redir_valid) begin
         fetch_pc_d = target;
         // A response still owed by memory must be swallowed when it finally shows up.
         if (state_q == S_WAIT) begin
            if (imem_rvalid) begin
               state_d   = S_IDLE;
               discard_d = 1'b0;
            end else begin
               discard_d = 1'b1;
            end
         end
      end else if (state_q == S_IDLE) begin
         if (accept) begin
            state_d       = S_WAIT;
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_pc_d = fetch_pc_q;
         end
      end else if (imem_rvalid) begin
         state_d   = S_IDLE;
         discard_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         fetch_pc_q    <= RESET_PC;
         inflight_pc_q <= '0;
         discard_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         discard_q     <= discard_d;
      end
   end

   fetch_fifo #(
      .WIDTH (2 * INSTR_W),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (redir_valid),
      .push_i      (push),
      .push_data_i ({imem_rdata, inflight_pc_q}),
      .pop_i       (pop),
      .pop_data_o  ({out_instr, out_pc}),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count)
   );

   assign out_valid   = ~fifo_empty;
   assign out_pcplus8 = out_valid ? out_pc + 32'd8 : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit: directed vectors plus randomized traffic
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   localparam int          QD  = 4;
   localparam logic [31:0] RPC = 32'h0000_3000;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req, imem_ready, imem_rvalid;
   logic [31:0] imem_addr, imem_rdata;
   logic        redir_valid;
   logic [1:0]  redir_kind;
   logic [31:0] redir_base, redir_imm, redir_reg;
   logic [25:0] redir_idx;
   logic        out_valid, out_ready;
   logic [31:0] out_instr, out_pc, out_pcplus8;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
      .clk(clk), .rst(rst),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .redir_valid(redir_valid), .redir_kind(redir_kind), .redir_base(redir_base),
      .redir_imm(redir_imm), .redir_idx(redir_idx), .redir_reg(redir_reg),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_pc(out_pc), .out_pcplus8(out_pcplus8)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: the output stream is consecutive words from the last restart point.
   logic [31:0] exp_pc, exp_fetch, dxor;
   int          occ;
   bit          stale;
   bit          mem_pending, resp_real;
   int          mem_lat;
   logic [31:0] mem_addr;
   int          lat_min, lat_max, ready_pct;
   bit          spur_en;
   logic [31:0] pops_q[$];
   logic [31:0] p8_q[$];
   logic [31:0] hs_q[$];

   typedef struct {
      logic [1:0]  kind;
      logic [31:0] base;
      logic [31:0] imm;
      logic [25:0] idx;
      logic [31:0] rreg;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[8];

   function automatic logic [31:0] model_target(input logic [1:0] k, input logic [31:0] base,
                                                input logic [31:0] imm, input logic [25:0] idx,
                                                input logic [31:0] r);
      if (k == 2'd0)      return base + 32'd4 + imm * 32'd4;
      else if (k == 2'd1) return (base & 32'hF000_0000) | ({6'd0, idx} * 32'd4);
      else                return r & 32'hFFFF_FFFC;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_pop(input string name, input int i, input logic [31:0] exp);
      logic [31:0] act;
      act = (i < pops_q.size()) ? pops_q[i] : 'x;
      chk(name, act, exp);
   endtask

   task automatic tick();
      bit hs_s, pop_s, redir_s, rst_s, rr_s;
      logic [31:0] tgt;
      #2;
      rst_s   = rst;
      redir_s = redir_valid;
      rr_s    = resp_real;
      hs_s    = imem_req & imem_ready;
      pop_s   = out_valid & out_ready;
      chk("imem_req", 32'(imem_req), 32'(!rst_s && !redir_s && !mem_pending && !rr_s && occ < QD));
      chk("out_valid", 32'(out_valid), 32'(occ != 0));
      if (hs_s && !rst_s) begin
         chk("imem_addr", imem_addr, exp_fetch);
         hs_q.push_back(imem_addr);
      end
      if (pop_s && !rst_s && !redir_s) begin
         chk("out_pc", out_pc, exp_pc);
         chk("out_instr", out_instr, exp_pc ^ dxor);
         chk("out_pcplus8", out_pcplus8, exp_pc + 32'd8);
         pops_q.push_back(out_pc);
         p8_q.push_back(out_pcplus8);
         exp_pc += 32'd4;
      end
      tgt = model_target(redir_kind, redir_base, redir_imm, redir_idx, redir_reg);
      @(posedge clk);
      #1;
      rst         = 1'b0;
      redir_valid = 1'b0;
      resp_real   = 1'b0;
      imem_rvalid = 1'b0;
      if (rst_s) begin
         occ = 0; stale = 0; mem_pending = 0;
         exp_pc = RPC; exp_fetch = RPC;
      end else begin
         if (redir_s) begin
            occ = 0;
            stale = mem_pending;
            exp_pc = tgt;
            exp_fetch = tgt;
         end else begin
            if (rr_s) begin
               if (stale) stale = 0;
               else occ++;
            end
            if (pop_s && occ > 0) occ--;
            if (hs_s) exp_fetch += 32'd4;
         end
         if (hs_s) begin
            mem_pending = 1;
            mem_addr = hs_q[$];
            mem_lat = int'($urandom_range(lat_max, lat_min));
         end
         if (mem_pending) begin
            if (mem_lat == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_addr ^ dxor;
               resp_real   = 1'b1;
               mem_pending = 0;
            end else begin
               mem_lat--;
            end
         end else if (spur_en && $urandom_range(0, 4) == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
         end
      end
      imem_ready = ($urandom_range(0, 99) < ready_pct);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      pops_q.delete(); p8_q.delete(); hs_q.delete();
   endtask

   task automatic wait_pops(input int n, input int budget, input string name);
      int k;
      k = 0;
      while (pops_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      if (pops_q.size() < n) begin
         checks++;
         errors++;
         $display("FAIL %s: timeout with %0d outputs, needed %0d", name, pops_q.size(), n);
      end
   endtask

   task automatic wait_pending(input string name);
      int k;
      k = 0;
      while (!mem_pending && k < 20) begin
         tick();
         k++;
      end
      if (!mem_pending) begin
         checks++;
         errors++;
         $display("FAIL %s: no request became outstanding", name);
      end
   endtask

   task automatic set_redir(input logic [1:0] k, input logic [31:0] b, input logic [31:0] im,
                            input logic [25:0] ix, input logic [31:0] r);
      redir_kind = k; redir_base = b; redir_imm = im; redir_idx = ix; redir_reg = r;
      redir_valid = 1'b1;
   endtask

   initial begin
      int k;
      vecs[0] = '{2'd0, 32'h0000_3004, 32'hFFFF_FFFE, 26'd0,          32'd0,         32'h0000_3000};
      vecs[1] = '{2'd1, 32'h0000_3000, 32'd0,         26'h000_0C40,   32'd0,         32'h0000_3100};
      vecs[2] = '{2'd2, 32'd0,         32'd0,         26'd0,          32'h0000_4003, 32'h0000_4000};
      vecs[3] = '{2'd3, 32'h0000_1000, 32'd0,         26'd0,          32'h1234_5677, 32'h1234_5674};
      vecs[4] = '{2'd0, 32'h0000_1000, 32'h0000_0010, 26'd0,          32'd0,         32'h0000_1044};
      vecs[5] = '{2'd1, 32'hA000_0000, 32'd0,         26'h3FF_FFFF,   32'd0,         32'hAFFF_FFFC};
      vecs[6] = '{2'd0, 32'hFFFF_FFF8, 32'h0000_0001, 26'd0,          32'd0,         32'h0000_0000};
      vecs[7] = '{2'd0, 32'h0000_2000, 32'h4000_0001, 26'd0,          32'd0,         32'h0000_2008};

      rst = 1'b1; imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
      redir_valid = 1'b0; redir_kind = '0; redir_base = '0; redir_imm = '0; redir_idx = '0; redir_reg = '0;
      out_ready = 1'b0;
      occ = 0; stale = 0; mem_pending = 0; resp_real = 0; mem_lat = 0; mem_addr = '0;
      exp_pc = RPC; exp_fetch = RPC; dxor = '0;
      lat_min = 0; lat_max = 0; ready_pct = 100; spur_en = 0;

      @(posedge clk);
      #2;
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_instr", out_instr, 32'd0);
      chk("rst_out_pcplus8", out_pcplus8, 32'd0);
      chk("rst_imem_addr", imem_addr, RPC);

      // Streaming from reset with a zero-wait memory
      out_ready = 1'b1;
      wait_pops(3, 40, "stream");
      chk_pop("stream_pc0", 0, 32'h3000);
      chk_pop("stream_pc1", 1, 32'h3004);
      chk_pop("stream_pc2", 2, 32'h3008);
      chk("stream_pcplus8_0", (p8_q.size() > 0) ? p8_q[0] : 'x, 32'h3008);

      // Back-pressure fills the queue to exactly QD entries
      do_reset();
      out_ready = 1'b0;
      repeat (20) tick();
      chk("bp_issued", 32'(hs_q.size()), 32'(QD));
      chk("bp_last_addr", (hs_q.size() > 0) ? hs_q[$] : 'x, 32'h300C);
      out_ready = 1'b1;
      wait_pops(4, 40, "bp_drain");
      for (int i = 0; i < 4; i++) chk_pop("bp_drain_pc", i, 32'h3000 + 32'(4 * i));
      k = 0;
      while (hs_q.size() < 5 && k < 20) begin tick(); k++; end
      chk("bp_resume_addr", (hs_q.size() > 4) ? hs_q[4] : 'x, 32'h3010);

      // Table of redirects, each issued while a response is outstanding
      for (int v = 0; v < 8; v++) begin
         do_reset();
         lat_min = 2; lat_max = 2; out_ready = 1'b1;
         wait_pending("vec_wait");
         set_redir(vecs[v].kind, vecs[v].base, vecs[v].imm, vecs[v].idx, vecs[v].rreg);
         pops_q.delete();
         tick();
         wait_pops(1, 60, "vec_out");
         chk_pop($sformatf("vec%0d_target", v), 0, vecs[v].exp);
      end

      // Fetch PC wraps at the top of the address space
      do_reset();
      lat_min = 0; lat_max = 0; out_ready = 1'b1;
      set_redir(2'd2, '0, '0, '0, 32'hFFFF_FFF8);
      tick();
      wait_pops(3, 40, "wrap");
      chk_pop("wrap_pc0", 0, 32'hFFFF_FFF8);
      chk_pop("wrap_pc1", 1, 32'hFFFF_FFFC);
      chk_pop("wrap_pc2", 2, 32'h0000_0000);

      // Redirect landing on the same edge as a response and a pop
      do_reset();
      out_ready = 1'b0;
      repeat (6) tick();
      out_ready = 1'b1;
      k = 0;
      while (!(resp_real && out_valid) && k < 30) begin tick(); k++; end
      chk("coinc_setup", 32'(resp_real && out_valid), 32'd1);
      set_redir(2'd2, '0, '0, '0, 32'h0000_5000);
      tick();
      pops_q.delete();
      chk("coinc_out_valid", 32'(out_valid), 32'd0);
      wait_pops(1, 40, "coinc");
      chk_pop("coinc_first_pc", 0, 32'h0000_5000);

      // Reset while waiting with three entries queued
      do_reset();
      out_ready = 1'b0; lat_min = 3; lat_max = 3;
      k = 0;
      while (!(occ == 3 && mem_pending) && k < 60) begin tick(); k++; end
      chk("rstwait_setup", 32'(occ == 3 && mem_pending), 32'd1);
      rst = 1'b1;
      tick();
      chk("rstwait_out_valid", 32'(out_valid), 32'd0);
      chk("rstwait_imem_addr", imem_addr, 32'h3000);
      pops_q.delete();
      lat_min = 0; lat_max = 0; out_ready = 1'b1;
      wait_pops(2, 40, "rstwait");
      chk_pop("rstwait_pc0", 0, 32'h3000);
      chk_pop("rstwait_pc1", 1, 32'h3004);

      // Randomized traffic: latency, ready, back-pressure, redirects, spurious responses, resets
      do_reset();
      dxor = 32'h1357_9BDF;
      lat_min = 0; lat_max = 3; ready_pct = 75; spur_en = 1;
      for (int c = 0; c < 4000; c++) begin
         out_ready = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 24) == 0)
            set_redir(2'($urandom), $urandom, $urandom, 26'($urandom), $urandom);
         if ($urandom_range(0, 599) == 0) rst = 1'b1;
         tick();
      end
      chk("random_progress", 32'(pops_q.size() > 200), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters SHALL be: RESET_PC, default 32'h0000_3000, first fetch address after reset; QDEPTH, default 4, fetch-queue entries (power of 2, >=2).
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 imem_req  out  1  fetch request valid; imem_addr  out  32  word-aligned fetch address.
REQ-005 imem_ready  in  1  memory accepts request this cycle (handshake = imem_req & imem_ready).
REQ-006 imem_rvalid  in  1  response valid; imem_rdata  in  32  instruction word.
REQ-007 redir_valid  in  1  redirect strobe; redir_kind  in  2  0=BR, 1=J, 2=JR, 3=reserved (treated as JR).
REQ-008 redir_base  in  32  PC of the branch/jump; redir_imm  in  32  sign-extended offset; redir_idx  in  26  jump index; redir_reg  in  32  register target.
REQ-009 out_valid  out  1; out_ready  in  1; out_instr  out  32; out_pc  out  32; out_pcplus8  out  32  (link value).

Function
REQ-010 Target SHALL be: BR = redir_base + 4 + {redir_imm[29:0],2'b00}; J = {redir_base[31:28], redir_idx, 2'b00}; JR = {redir_reg[31:2],2'b00}; all mod 2^32.
REQ-011 Control FSM SHALL have states IDLE (no request outstanding) and WAIT (one request accepted, response pending); at most one outstanding request.
REQ-012 imem_req SHALL assert in IDLE when (queue count) < QDEPTH and redir_valid=0; imem_addr = fetch PC.
REQ-013 On imem_req & imem_ready: IDLE->WAIT, fetch PC <= fetch PC + 4, and the issued address is recorded as the in-flight PC.
REQ-014 In WAIT, imem_rvalid SHALL push {imem_rdata, in-flight PC} into the queue and return to IDLE, unless the discard flag is set, in which case the data is dropped, discard cleared, state -> IDLE.
REQ-015 imem_rvalid in IDLE SHALL be ignored.
REQ-016 Queue head SHALL drive out_instr/out_pc; out_pcplus8 = out_pc + 8; out_valid = queue non-empty; pop on out_valid & out_ready.
REQ-017 Push and pop in the same cycle SHALL leave count unchanged; push is never attempted when full (guaranteed by REQ-012).
REQ-018 redir_valid SHALL, in the same edge: set fetch PC to target, empty the queue (any simultaneous pop or push is void), set discard if state is WAIT and no response arrives that cycle; a response arriving that cycle is dropped.
REQ-019 No imem_req SHALL be issued in the redirect cycle; the first fetch from the target is requested no earlier than the next cycle (after the discarded response, if one is pending).
REQ-020 Fetch PC SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-021 Best case throughput: one instruction per 2 cycles (issue, response); redirect-to-out_valid latency with zero-wait memory: 2 cycles.

Reset
REQ-022 On rst: fetch PC = RESET_PC, state IDLE, discard 0, queue empty, out_valid 0, imem_req 0; output data fields 0.
REQ-023 rst mid-operation SHALL abandon any outstanding request; instruction memory shares rst, so no stale response is expected and any that arrives is ignored per REQ-015.

Structure
REQ-024 Shared package SHALL hold redir_kind encodings (BR/J/JR), RESET_PC default and instruction width constant 32.
REQ-025 The queue SHALL be a sub-module fetch_fifo (parameterised width and depth, sync reset, flush input, push/pop/full/empty/count).

Verification
REQ-026 Reset then zero-wait memory returning addr as data, out_ready=1 -> out_pc 0x3000, 0x3004, 0x3008 in order, out_pcplus8 = 0x3008 for first.
REQ-027 out_ready=0 for 20 cycles -> exactly QDEPTH entries (0x3000..0x300C) queued, imem_req low afterwards; release -> drained in order, fetching resumes at 0x3010.
REQ-028 BR redirect base 0x3004, imm 0xFFFF_FFFE while in WAIT -> pending response dropped, queue empty, next out_pc = 0x3000.
REQ-029 J with base 0x3000, idx 0x0000C40 -> next out_pc 0x0000_3100; JR reg 0x0000_4003 -> next out_pc 0x0000_4000.
REQ-030 Redirect coincident with imem_rvalid and out_ready -> no output from old stream after the edge, first new out_pc = target.
REQ-031 rst asserted in WAIT with queue of 3 -> next cycle out_valid 0, imem_addr 0x3000, fetch restarts cleanly.
